// File: rtl/es_pkg.sv
// es_pkg: shared constants and types for the entrada_salida I/O unit.
// Holds the I/O register map, TCTRL/TEST bit positions and the timer state type.
package es_pkg;

   // I/O register addresses (data address bits 6:0)
   localparam logic [6:0] DIR_S0      = 7'h00;
   localparam logic [6:0] DIR_S1      = 7'h01;
   localparam logic [6:0] DIR_S2      = 7'h02;
   localparam logic [6:0] DIR_S3      = 7'h03;
   localparam logic [6:0] DIR_E0      = 7'h04;
   localparam logic [6:0] DIR_E1      = 7'h05;
   localparam logic [6:0] DIR_E2      = 7'h06;
   localparam logic [6:0] DIR_E3      = 7'h07;
   localparam logic [6:0] DIR_TCARGA  = 7'h08;
   localparam logic [6:0] DIR_TCTRL   = 7'h09;
   localparam logic [6:0] DIR_TEST    = 7'h0A;
   localparam logic [6:0] DIR_TCUENTA = 7'h0B;

   // TCTRL bit positions
   localparam int TCTRL_EN    = 0;
   localparam int TCTRL_AUTO  = 1;
   localparam int TCTRL_IRQEN = 2;

   // TEST bit positions
   localparam int TEST_FLAG = 0;
   localparam int TEST_RUN  = 1;

   // Timer FSM states
   typedef enum logic {
      PARADO   = 1'b0,
      CONTANDO = 1'b1
   } estado_t;

endpackage

// File: rtl/es_temporizador.sv
// es_temporizador: prescaled down-counting timer with sticky expiry flag.
// Owns the timer FSM, prescaler, counter, TCARGA/TCTRL control bits, FLAG and irq.
// Register writes arrive as decoded one-cycle strobes from the top.
module es_temporizador
   import es_pkg::*;
#(
   parameter int PRESC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_carga,
   input  logic       wr_ctrl,
   input  logic       wr_test,
   input  logic [7:0] dato_in,
   output logic [7:0] carga,
   output logic [7:0] cuenta,
   output logic       auto_rec,
   output logic       irqen,
   output logic       flag,
   output logic       irq,
   output estado_t    estado
);

   localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

   estado_t       estado_q, estado_d;
   logic [PW-1:0] presc_q,  presc_d;
   logic [7:0]    cuenta_q, cuenta_d;
   logic [7:0]    carga_q,  carga_d;
   logic          auto_q,   auto_d;
   logic          irqen_q,  irqen_d;
   logic          flag_q,   flag_d;
   logic          irq_q,    irq_d;
   logic          tick;
   logic          expira;

   // Next-state: FSM transitions, prescaler, counter, control bits and FLAG
   always_comb begin
      estado_d = estado_q;
      presc_d  = presc_q;
      cuenta_d = cuenta_q;
      carga_d  = carga_q;
      auto_d   = auto_q;
      irqen_d  = irqen_q;
      flag_d   = flag_q;
      expira   = 1'b0;
      tick     = (estado_q == CONTANDO) && (presc_q == PRESC_MAX);

      // New TCARGA is only picked up at the next load or reload
      if (wr_carga) begin
         carga_d = dato_in;
      end

      if (estado_q == PARADO) begin
         if (wr_ctrl && dato_in[TCTRL_EN]) begin
            estado_d = CONTANDO;
            cuenta_d = carga_q;
            presc_d  = '0;
         end
      end else begin
         if (wr_ctrl && !dato_in[TCTRL_EN]) begin
            // Software stop: count is held, no tick processed on this edge
            estado_d = PARADO;
         end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               if (cuenta_q != 8'h00) begin
                  cuenta_d = cuenta_q - 8'h01;
               end else begin
                  expira = 1'b1;
                  if (auto_q) begin
                     cuenta_d = carga_q;
                  end else begin
                     estado_d = PARADO;
                  end
               end
            end
         end
      end

      // AUTO/IRQEN follow every TCTRL write; EN is the FSM state itself
      if (wr_ctrl) begin
         auto_d  = dato_in[TCTRL_AUTO];
         irqen_d = dato_in[TCTRL_IRQEN];
      end

      // Clear first so that a simultaneous expiry wins
      if (wr_test && dato_in[TEST_FLAG]) begin
         flag_d = 1'b0;
      end
      if (expira) begin
         flag_d = 1'b1;
      end

      // irq comes straight from a flop, so it rises together with FLAG
      irq_d = flag_d & irqen_d;
   end

   // Timer state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= PARADO;
         presc_q  <= '0;
         cuenta_q <= 8'h00;
         carga_q  <= 8'h00;
         auto_q   <= 1'b0;
         irqen_q  <= 1'b0;
         flag_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         presc_q  <= presc_d;
         cuenta_q <= cuenta_d;
         carga_q  <= carga_d;
         auto_q   <= auto_d;
         irqen_q  <= irqen_d;
         flag_q   <= flag_d;
         irq_q    <= irq_d;
      end
   end

   assign carga    = carga_q;
   assign cuenta   = cuenta_q;
   assign auto_rec = auto_q;
   assign irqen    = irqen_q;
   assign flag     = flag_q;
   assign irq      = irq_q;
   assign estado   = estado_q;

endmodule

// File: rtl/entrada_salida.sv
// entrada_salida: memory-mapped I/O unit in the upper half of the data space.
// Four registered output ports, four synchronised input ports and an optional
// timer. Define ES_TIMER_EN to compile in the timer (addresses 0x08-0x0B and irq);
// without it those addresses are unmapped and irq is tied low.
//
// Bus handshake: an access is the single cycle where activar=1. With escribir=1
// the write lands on that rising edge; with escribir=0 dato_out is the
// combinational read of current state. dato_out is 0x00 otherwise.
module entrada_salida
   import es_pkg::*;
#(
   parameter int PRESC       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       activar,
   input  logic       escribir,
   input  logic [6:0] direccion,
   input  logic [7:0] dato_in,
   output logic [7:0] dato_out,
   input  logic [7:0] e0,
   input  logic [7:0] e1,
   input  logic [7:0] e2,
   input  logic [7:0] e3,
   output logic [7:0] s0,
   output logic [7:0] s1,
   output logic [7:0] s2,
   output logic [7:0] s3,
   output logic       irq
);

   logic [7:0] s_q [4];
   logic [7:0] s_d [4];
   logic [7:0] sync_q [4][SYNC_STAGES];
   logic [7:0] sync_d [4][SYNC_STAGES];
   logic [7:0] e_in [4];
   logic       wr;

   assign wr    = activar & escribir;
   assign e_in[0] = e0;
   assign e_in[1] = e1;
   assign e_in[2] = e2;
   assign e_in[3] = e3;

   // Output port write decode
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         s_d[i] = s_q[i];
      end
      if (wr) begin
         case (direccion)
            DIR_S0:  s_d[0] = dato_in;
            DIR_S1:  s_d[1] = dato_in;
            DIR_S2:  s_d[2] = dato_in;
            DIR_S3:  s_d[3] = dato_in;
            default: ;
         endcase
      end
   end

   // Input synchroniser shift: stage 0 samples the pin, last stage is readable
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         sync_d[p][0] = e_in[p];
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[p][k] = sync_q[p][k-1];
         end
      end
   end

   // Port and synchroniser registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 4; p++) begin
            s_q[p] <= 8'h00;
            for (int k = 0; k < SYNC_STAGES; k++) begin
               sync_q[p][k] <= 8'h00;
            end
         end
      end else begin
         for (int p = 0; p < 4; p++) begin
            s_q[p] <= s_d[p];
            for (int k = 0; k < SYNC_STAGES; k++) begin
               sync_q[p][k] <= sync_d[p][k];
            end
         end
      end
   end

   assign s0 = s_q[0];
   assign s1 = s_q[1];
   assign s2 = s_q[2];
   assign s3 = s_q[3];

`ifdef ES_TIMER_EN
   logic [7:0] t_carga;
   logic [7:0] t_cuenta;
   logic       t_auto;
   logic       t_irqen;
   logic       t_flag;
   logic       t_irq;
   estado_t    t_estado;
   logic [7:0] reg_tctrl;
   logic [7:0] reg_test;

   es_temporizador #(
      .PRESC (PRESC)
   ) u_temporizador (
      .clk      (clk),
      .reset    (reset),
      .wr_carga (wr && (direccion == DIR_TCARGA)),
      .wr_ctrl  (wr && (direccion == DIR_TCTRL)),
      .wr_test  (wr && (direccion == DIR_TEST)),
      .dato_in  (dato_in),
      .carga    (t_carga),
      .cuenta   (t_cuenta),
      .auto_rec (t_auto),
      .irqen    (t_irqen),
      .flag     (t_flag),
      .irq      (t_irq),
      .estado   (t_estado)
   );

   // Assemble TCTRL and TEST views from timer state
   always_comb begin
      reg_tctrl              = 8'h00;
      reg_tctrl[TCTRL_EN]    = (t_estado == CONTANDO);
      reg_tctrl[TCTRL_AUTO]  = t_auto;
      reg_tctrl[TCTRL_IRQEN] = t_irqen;
      reg_test               = 8'h00;
      reg_test[TEST_FLAG]    = t_flag;
      reg_test[TEST_RUN]     = (t_estado == CONTANDO);
   end

   assign irq = t_irq;
`else
   assign irq = 1'b0;
`endif

   // Combinational read mux, quiet unless this is a read access
   always_comb begin
      dato_out = 8'h00;
      if (activar && !escribir) begin
         case (direccion)
            DIR_S0:      dato_out = s_q[0];
            DIR_S1:      dato_out = s_q[1];
            DIR_S2:      dato_out = s_q[2];
            DIR_S3:      dato_out = s_q[3];
            DIR_E0:      dato_out = sync_q[0][SYNC_STAGES-1];
            DIR_E1:      dato_out = sync_q[1][SYNC_STAGES-1];
            DIR_E2:      dato_out = sync_q[2][SYNC_STAGES-1];
            DIR_E3:      dato_out = sync_q[3][SYNC_STAGES-1];
`ifdef ES_TIMER_EN
            DIR_TCARGA:  dato_out = t_carga;
            DIR_TCTRL:   dato_out = reg_tctrl;
            DIR_TEST:    dato_out = reg_test;
            DIR_TCUENTA: dato_out = t_cuenta;
`endif
            default:     dato_out = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_entrada_salida.sv
// tb_entrada_salida: directed bench for entrada_salida (PRESC=4, SYNC_STAGES=2).
// Timer scenarios are exercised when ES_TIMER_EN is defined; otherwise the
// timer addresses are checked as unmapped and irq as tied low.
module tb_entrada_salida;

   logic       clk;
   logic       reset;
   logic       activar;
   logic       escribir;
   logic [6:0] direccion;
   logic [7:0] dato_in;
   logic [7:0] dato_out;
   logic [7:0] e0, e1, e2, e3;
   logic [7:0] s0, s1, s2, s3;
   logic       irq;

   int n_checks;
   int n_errors;

   entrada_salida #(
      .PRESC       (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .activar   (activar),
      .escribir  (escribir),
      .direccion (direccion),
      .dato_in   (dato_in),
      .dato_out  (dato_out),
      .e0        (e0),
      .e1        (e1),
      .e2        (e2),
      .e3        (e3),
      .s0        (s0),
      .s1        (s1),
      .s2        (s2),
      .s3        (s3),
      .irq       (irq)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   // One write access; returns on the falling edge after the write edge
   task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      activar   = 1'b1;
      escribir  = 1'b1;
      direccion = a;
      dato_in   = d;
      @(negedge clk);
      activar   = 1'b0;
      escribir  = 1'b0;
   endtask

   // Combinational read, no clock edge consumed
   task automatic bus_read(input logic [6:0] a, output logic [7:0] d);
      activar   = 1'b1;
      escribir  = 1'b0;
      direccion = a;
      #1;
      d         = dato_out;
      activar   = 1'b0;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] rd;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      activar   = 1'b0;
      escribir  = 1'b0;
      direccion = 7'h00;
      dato_in   = 8'h00;
      e0 = 8'h00; e1 = 8'h00; e2 = 8'h00; e3 = 8'h00;

      // Reset held for two edges
      wait_edges(2);
      reset = 1'b0;
      check_val("rst_s0", s0, 8'h00);
      check_val("rst_s1", s1, 8'h00);
      check_val("rst_s2", s2, 8'h00);
      check_val("rst_s3", s3, 8'h00);
      check_val("rst_irq", {7'b0, irq}, 8'h00);
      bus_read(7'h00, rd); check_val("rst_rd_00", rd, 8'h00);
      bus_read(7'h09, rd); check_val("rst_rd_09", rd, 8'h00);

      // Output port write and readback
      bus_write(7'h02, 8'hA5);
      check_val("s2_pin", s2, 8'hA5);
      bus_read(7'h02, rd); check_val("s2_rd", rd, 8'hA5);
      bus_write(7'h00, 8'h11);
      bus_write(7'h03, 8'hC3);
      check_val("s0_pin", s0, 8'h11);
      check_val("s3_pin", s3, 8'hC3);
      bus_read(7'h03, rd); check_val("s3_rd", rd, 8'hC3);

      // dato_out quiet during a write access
      @(negedge clk);
      activar = 1'b1; escribir = 1'b1; direccion = 7'h02; dato_in = 8'hA5;
      #1; check_val("rd_quiet_wr", dato_out, 8'h00);
      @(negedge clk);
      activar = 1'b0; escribir = 1'b0;

      // Write strobe without activar is ignored
      @(negedge clk);
      activar = 1'b0; escribir = 1'b1; direccion = 7'h02; dato_in = 8'h5A;
      @(negedge clk);
      escribir = 1'b0;
      check_val("s2_no_act", s2, 8'hA5);

      // Writes to read-only and unmapped addresses change nothing
      bus_write(7'h05, 8'hFF);
      bus_read(7'h05, rd); check_val("e1_ro", rd, 8'h00);
      bus_write(7'h20, 8'h77);
      bus_read(7'h20, rd); check_val("unmapped_rd", rd, 8'h00);
      check_val("s1_untouched", s1, 8'h00);
      check_val("s2_untouched", s2, 8'hA5);

      // Input synchroniser latency
      @(negedge clk);
      e1 = 8'h3C;
      e3 = 8'h81;
      bus_read(7'h05, rd); check_val("e1_sync0", rd, 8'h00);
      wait_edges(1);
      bus_read(7'h05, rd); check_val("e1_sync1", rd, 8'h00);
      wait_edges(1);
      bus_read(7'h05, rd); check_val("e1_sync2", rd, 8'h3C);
      bus_read(7'h07, rd); check_val("e3_sync2", rd, 8'h81);

`ifdef ES_TIMER_EN
      // One-shot: TCARGA=2, expiry after edge 12
      bus_write(7'h08, 8'h02);
      bus_read(7'h08, rd); check_val("tcarga_rd", rd, 8'h02);
      bus_write(7'h09, 8'h05);                       // edge 0
      bus_read(7'h09, rd); check_val("tctrl_run", rd, 8'h05);
      wait_edges(5);                                  // after edge 5
      bus_read(7'h0B, rd); check_val("cuenta_e5", rd, 8'h01);
      wait_edges(6);                                  // after edge 11
      bus_read(7'h0A, rd); check_val("test_e11", rd, 8'h02);
      check_val("irq_e11", {7'b0, irq}, 8'h00);
      wait_edges(1);                                  // after edge 12
      bus_read(7'h0A, rd); check_val("test_e12", rd, 8'h01);
      check_val("irq_e12", {7'b0, irq}, 8'h01);
      bus_read(7'h09, rd); check_val("tctrl_done", rd, 8'h04);
      bus_write(7'h0A, 8'h01);
      check_val("irq_clr", {7'b0, irq}, 8'h00);
      bus_read(7'h0A, rd); check_val("test_clr", rd, 8'h00);

      // Auto-reload: TCARGA=0, expiry on every tick (edges 4, 8, 12)
      bus_write(7'h08, 8'h00);
      bus_write(7'h09, 8'h03);                       // edge 0
      wait_edges(3);                                  // after edge 3
      bus_read(7'h0A, rd); check_val("auto_e3", rd, 8'h02);
      wait_edges(1);                                  // after edge 4
      bus_read(7'h0A, rd); check_val("auto_e4", rd, 8'h03);
      check_val("auto_noirq", {7'b0, irq}, 8'h00);
      bus_write(7'h0A, 8'h01);                       // clear at edge 5
      bus_read(7'h0A, rd); check_val("auto_clr5", rd, 8'h02);
      wait_edges(2);                                  // after edge 7
      bus_write(7'h0A, 8'h01);                       // clear at expiry edge 8
      bus_read(7'h0A, rd); check_val("set_wins", rd, 8'h03);
      bus_write(7'h0A, 8'h01);                       // clear at edge 9
      bus_read(7'h0A, rd); check_val("auto_clr9", rd, 8'h02);
      bus_write(7'h09, 8'h00);                       // stop at edge 10
      bus_read(7'h0A, rd); check_val("auto_stop", rd, 8'h00);
      bus_read(7'h09, rd); check_val("tctrl_stop", rd, 8'h00);

      // Reset mid-count with FLAG set and TCUENTA=5
      bus_write(7'h09, 8'h05);                       // one-shot, TCARGA=0
      wait_edges(4);                                  // expired after edge 4
      check_val("pre_rst_irq", {7'b0, irq}, 8'h01);
      bus_write(7'h08, 8'h05);
      bus_write(7'h09, 8'h05);
      bus_read(7'h0B, rd); check_val("pre_rst_cnt", rd, 8'h05);
      bus_read(7'h0A, rd); check_val("pre_rst_test", rd, 8'h03);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus_read(7'h0B, rd); check_val("rst_cnt", rd, 8'h00);
      bus_read(7'h0A, rd); check_val("rst_test", rd, 8'h00);
      bus_read(7'h09, rd); check_val("rst_tctrl", rd, 8'h00);
      bus_read(7'h08, rd); check_val("rst_tcarga", rd, 8'h00);
      check_val("rst_irq2", {7'b0, irq}, 8'h00);
      check_val("rst_s2", s2, 8'h00);
`else
      // Timer compiled out: 0x08-0x0B unmapped, irq low
      bus_write(7'h08, 8'h02);
      bus_write(7'h09, 8'h07);
      bus_read(7'h08, rd); check_val("nt_tcarga", rd, 8'h00);
      bus_read(7'h09, rd); check_val("nt_tctrl", rd, 8'h00);
      wait_edges(12);
      bus_read(7'h0A, rd); check_val("nt_test", rd, 8'h00);
      bus_read(7'h0B, rd); check_val("nt_tcuenta", rd, 8'h00);
      check_val("nt_irq", {7'b0, irq}, 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/entrada_salida.md
# entrada_salida

Memory-mapped I/O unit for the 8-bit single-cycle processor. Occupies the upper half of the data address space: the datapath drives it whenever the selected data address has bit 7 set, and its read data feeds the memory/I/O result mux towards the register file. It provides:
- four output ports and four synchronised input ports;
- a prescaled down-counting timer with a sticky expiry flag and an interrupt request.

## Interface
- PRESC, 4: clock cycles per timer tick (≥2).
- SYNC_STAGES, 2: flip-flop stages on each input port (≥2).

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge of clk
- activar  in  1  access strobe (data-memory enable AND address bit 7)
- escribir  in  1  write when activar=1, read otherwise
- direccion  in  7  I/O register address (data address bits 6:0)
- dato_in  in  8  write data (register-file read port 1)
- dato_out  out  8  read data, combinational
- e0, e1, e2, e3  in  8 each  asynchronous external input ports
- s0, s1, s2, s3  out  8 each  registered output ports
- irq  out  1  timer interrupt request

## Operation
- Register map:
  - 0x00–0x03: S0–S3, read/write; drive s0–s3.
  - 0x04–0x07: E0–E3, read-only; last synchroniser stage.
  - 0x08: TCARGA, read/write.
  - 0x09: TCTRL, read/write. bit0 EN, bit1 AUTO, bit2 IRQEN; bits 7:3 read 0.
  - 0x0A: TEST. bit0 FLAG (sticky, write 1 to clear), bit1 running; bits 7:2 read 0.
  - 0x0B: TCUENTA, read-only.
  - All other addresses read 0x00; writes to them are ignored.
- Writes occur on the rising edge when activar=1 and escribir=1. Writes to read-only addresses are ignored.
- Reads are combinational from current state. dato_out=0x00 whenever activar=0 or escribir=1.
- Timer FSM, states PARADO and CONTANDO:
  - PARADO → CONTANDO on a TCTRL write with EN=1. On that edge, cuenta←TCARGA and presc←0.
  - CONTANDO → PARADO on a TCTRL write with EN=0. cuenta is held.
  - In CONTANDO, presc increments every clock. A tick occurs when presc=PRESC-1; presc then wraps to 0.
  - On a tick with cuenta≠0: cuenta←cuenta-1.
  - On a tick with cuenta=0: FLAG←1. If AUTO=1, cuenta←TCARGA and stay in CONTANDO. Otherwise EN←0 and go to PARADO.
- Expiry period is (TCARGA+1)·PRESC clocks. All timer arithmetic is 8-bit unsigned; there is no wrap below 0.
- A TCARGA write during CONTANDO takes effect only at the next load or reload.
- A TCTRL write with EN=1 while already in CONTANDO updates AUTO/IRQEN only; it does not restart the count.
- If expiry and a FLAG clear happen in the same cycle, set wins.
- irq = FLAG & IRQEN, registered-source, glitch-free.

## Timing
- Reset values: s0–s3=0x00, irq=0, TCARGA=TCTRL=TCUENTA=0, FLAG=0, presc=0, FSM=PARADO, synchroniser flops=0.
- Write latency: a port or register changes on the write edge and is visible to reads and on the pins in the following cycle.
- Input latency: an e* change is readable after SYNC_STAGES rising edges.
- Timer: with TCTRL written at edge 0, FLAG rises after edge (TCARGA+1)·PRESC.
- Reset asserted mid-count aborts the timer at that edge; nothing is preserved.

## Configuration
- ES_TIMER_EN defined: timer, FSM and irq are compiled in as above.
- ES_TIMER_EN undefined:
  - addresses 0x08–0x0B behave as unmapped (read 0x00, writes ignored);
  - irq is tied to 0;
  - no timer flops are present.

## Structure
- Package es_pkg holds:
  - address constants DIR_S0…DIR_TCUENTA;
  - TCTRL/TEST bit-position constants;
  - timer state enum estado_t {PARADO, CONTANDO}.
- One sub-module, es_temporizador: FSM, prescaler, counter, FLAG. The top module keeps port registers, synchronisers and the read mux.

## Test plan
- Reset: hold reset 2 cycles → s0–s3=0x00, irq=0, reads of 0x00 and 0x09 return 0x00.
- Write 0xA5 to 0x02 → s2=0xA5 next cycle and a read of 0x02 returns 0xA5. The same write with activar=0 → s2 unchanged. A write to 0x05 → no effect.
- Input sync: e1 changes 0x00→0x3C → read of 0x05 returns 0x00 for 2 edges, then 0x3C.
- One-shot, PRESC=4: TCARGA=2, write TCTRL=0x05 → FLAG and irq rise after edge 12, TCTRL reads 0x04. Writing 0x01 to 0x0A → irq=0 next cycle.
- Auto-reload: TCARGA=0, TCTRL=0x03 → a tick every 4 clocks, expiring every tick. A clear issued on an expiry edge → FLAG remains 1.
- Reset while CONTANDO with TCUENTA=5 → next cycle TCUENTA=0, FSM=PARADO, FLAG=0.
